ex_muldiv_stage: RTL and testbench

- Parametrised multi-cycle multiply/divide execution unit with architectural HI/LO registers.
- Sits in the EX stage beside the single-cycle ALU path and reuses the same RS/RT forwarding-mux convention.
- Executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, without blocking the pipeline.
- Stalls EX only on a HI/LO hazard: MFHI/MFLO, MTHI/MTLO, or a new mul/div while an operation is running.

---
 rtl/ex_muldiv_stage.sv | 190 +++++++++++++++++++
 tb/tb_ex_muldiv_stage.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_stage.sv
// rtl/ex_muldiv_stage.sv - iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers
// Optional feature macro MULDIV_EARLY_OUT_EN: multiplies leave RUN once the remaining multiplier bits are zero.
module ex_muldiv_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic              i_flush,
    input  logic [2:0]        i_muldiv_op,
    input  logic              i_mfhilo,
    input  logic              i_hilo_sel,
    input  logic [DATA_W-1:0] i_read_data_1,
    input  logic [DATA_W-1:0] i_read_data_2,
    input  logic [DATA_W-1:0] i_forwarded_value_a,
    input  logic [DATA_W-1:0] i_forwarded_value_b,
    input  logic              i_use_forwarded_a,
    input  logic              i_use_forwarded_b,
    output logic              o_stall,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo,
    output logic [DATA_W-1:0] o_hilo_read,
    output logic              o_div_by_zero
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    // Multiply: running product. Divide: {remainder, quotient/dividend}.
    logic [2*DATA_W-1:0] acc_q, acc_d;
    // Multiply: left-shifting multiplicand. Divide: divisor in the low half.
    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    // Multiply: right-shifting multiplier. Divide: raw dividend kept for the divide-by-zero result.
    logic [DATA_W-1:0]   mplr_q, mplr_d;
    logic                is_div_q, is_div_d;
    logic                dz_q, dz_d;
    logic                res_neg_q, res_neg_d;
    logic                rem_neg_q, rem_neg_d;

    logic [DATA_W-1:0]   op_a, op_b, abs_a, abs_b, mplr_shift, quo, rem;
    logic                op_is_md, op_is_div, op_signed, sign_a, sign_b, hilo_op, issue;
    logic [DATA_W:0]     div_trial;
    logic [2*DATA_W-1:0] div_step;

    assign op_a = i_use_forwarded_a ? i_forwarded_value_a : i_read_data_1;
    assign op_b = i_use_forwarded_b ? i_forwarded_value_b : i_read_data_2;

    assign op_is_md  = (i_muldiv_op >= OP_MULT) && (i_muldiv_op <= OP_DIVU);
    assign op_is_div = (i_muldiv_op == OP_DIV) || (i_muldiv_op == OP_DIVU);
    assign op_signed = (i_muldiv_op == OP_MULT) || (i_muldiv_op == OP_DIV);
    assign sign_a    = op_signed & op_a[DATA_W-1];
    assign sign_b    = op_signed & op_b[DATA_W-1];
    assign abs_a     = sign_a ? -op_a : op_a;
    assign abs_b     = sign_b ? -op_b : op_b;
    assign hilo_op   = i_mfhilo || ((i_muldiv_op >= OP_MULT) && (i_muldiv_op <= OP_MTLO));

    assign issue = i_valid & ~i_flush & ~o_stall;

    assign quo        = acc_q[DATA_W-1:0];
    assign rem        = acc_q[2*DATA_W-1:DATA_W];
    assign mplr_shift = mplr_q >> 1;

    // Restoring step: a borrow in the top bit means the shifted remainder stays.
    assign div_trial = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]} - {1'b0, mcand_q[DATA_W-1:0]};
    assign div_step  = div_trial[DATA_W] ? {acc_q[2*DATA_W-2:0], 1'b0}
                                         : {div_trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            is_div_q  <= 1'b0;
            dz_q      <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            is_div_q  <= is_div_d;
            dz_q      <= dz_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (issue && op_is_md) state_d = S_RUN;
            S_RUN: begin
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
`ifdef MULDIV_EARLY_OUT_EN
                if (!is_div_q && (mplr_shift == '0)) state_d = S_FIX;
`endif
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy        = (state_q != S_IDLE);
        o_div_by_zero = (state_q == S_FIX) && dz_q;
        o_stall       = o_busy & i_valid & hilo_op;
        o_hi          = hi_q;
        o_lo          = lo_q;
        o_hilo_read   = i_hilo_sel ? hi_q : lo_q;
    end

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        is_div_d  = is_div_q;
        dz_d      = dz_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        case (state_q)
            S_IDLE: begin
                if (issue && op_is_md) begin
                    is_div_d  = op_is_div;
                    dz_d      = op_is_div && (op_b == '0);
                    res_neg_d = sign_a ^ sign_b;
                    rem_neg_d = sign_a;
                    cnt_d     = CNT_W'(DATA_W);
                    if (op_is_div) begin
                        acc_d   = {{DATA_W{1'b0}}, abs_a};
                        mcand_d = {{DATA_W{1'b0}}, abs_b};
                        mplr_d  = op_a;
                    end else begin
                        acc_d   = '0;
                        mcand_d = {{DATA_W{1'b0}}, abs_a};
                        mplr_d  = abs_b;
                    end
                end else if (issue && (i_muldiv_op == OP_MTHI)) begin
                    hi_d = op_a;
                end else if (issue && (i_muldiv_op == OP_MTLO)) begin
                    lo_d = op_a;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (is_div_q) begin
                    acc_d = div_step;
                end else begin
                    if (mplr_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d = mcand_q << 1;
                    mplr_d  = mplr_shift;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    if (dz_q) begin
                        hi_d = mplr_q;
                        lo_d = '1;
                    end else begin
                        lo_d = res_neg_q ? -quo : quo;
                        hi_d = rem_neg_q ? -rem : rem;
                    end
                end else begin
                    {hi_d, lo_d} = res_neg_q ? -acc_q : acc_q;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ex_muldiv_stage.sv
// tb/tb_ex_muldiv_stage.sv - self-checking bench for ex_muldiv_stage against an arithmetic HI/LO model
module tb_ex_muldiv_stage;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, in_flush = 1'b0, in_mf = 1'b0, in_sel = 1'b0;
    logic [2:0]   in_op = 3'd0;
    logic [W-1:0] rd1 = '0, rd2 = '0, fa = '0, fb = '0;
    logic         ua = 1'b0, ub = 1'b0;
    logic         o_stall, o_busy, o_div_by_zero;
    logic [W-1:0] o_hi, o_lo, o_hilo_read;

    int n_checks = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [W-1:0] m_hi = '0, m_lo = '0, m_pend_hi = '0, m_pend_lo = '0;
    int           m_rem = 0;
    logic         m_dz = 1'b0, m_last_stall = 1'b0;

    ex_muldiv_stage #(.DATA_W(W)) dut (
        .clk(clk), .reset(rst_n), .i_valid(in_valid), .i_flush(in_flush),
        .i_muldiv_op(in_op), .i_mfhilo(in_mf), .i_hilo_sel(in_sel),
        .i_read_data_1(rd1), .i_read_data_2(rd2),
        .i_forwarded_value_a(fa), .i_forwarded_value_b(fb),
        .i_use_forwarded_a(ua), .i_use_forwarded_b(ub),
        .o_stall(o_stall), .o_busy(o_busy), .o_hi(o_hi), .o_lo(o_lo),
        .o_hilo_read(o_hilo_read), .o_div_by_zero(o_div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result as {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] model_result(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint q, r;
        logic [63:0] qv, rv, p;
        p = '0;
        case (op)
            3'd1: p = 64'(longint'($signed(a)) * longint'($signed(b)));
            3'd2: p = {32'b0, a} * {32'b0, b};
            3'd3: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    qv = q; rv = r;
                    p = {rv[31:0], qv[31:0]};
                end
            end
            3'd4: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    // Number of cycles o_busy stays high after the capture edge.
    function automatic int model_latency(input logic [2:0] op, input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        logic [W-1:0] m;
        int n;
        if (op == 3'd1 || op == 3'd2) begin
            m = (op == 3'd1 && b[W-1]) ? -b : b;
            n = 0;
            while (m != 0) begin n++; m = m >> 1; end
            if (n == 0) n = 1;
            return n + 1;
        end
`endif
        return W + 1;
    endfunction

    function automatic logic exp_stall();
        return (m_rem != 0) && in_valid && (in_mf || (in_op >= 3'd1 && in_op <= 3'd6));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [W-1:0] a, b;
        logic [63:0]  res;
        if (!rst_n) begin
            m_hi <= '0; m_lo <= '0; m_rem <= 0; m_dz <= 1'b0; m_last_stall <= 1'b0;
        end else begin
            m_last_stall <= exp_stall();
            a = ua ? fa : rd1;
            b = ub ? fb : rd2;
            if (m_rem != 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin m_hi <= m_pend_hi; m_lo <= m_pend_lo; end
            end else if (in_valid && !in_flush) begin
                if (in_op >= 3'd1 && in_op <= 3'd4) begin
                    res = model_result(in_op, a, b);
                    m_pend_hi <= res[63:32];
                    m_pend_lo <= res[31:0];
                    m_rem <= model_latency(in_op, b);
                    m_dz <= (in_op >= 3'd3) && (b == 0);
                end else if (in_op == 3'd5) m_hi <= a;
                else if (in_op == 3'd6) m_lo <= a;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 64'(o_busy), 64'(m_rem != 0));
            check("stall", 64'(o_stall), 64'(exp_stall()));
            check("hi", 64'(o_hi), 64'(m_hi));
            check("lo", 64'(o_lo), 64'(m_lo));
            check("hilo_read", 64'(o_hilo_read), 64'(in_sel ? m_hi : m_lo));
            check("div_by_zero", 64'(o_div_by_zero), 64'(m_dz && m_rem == 1));
        end
    end

    task automatic set_instr(input logic v, input logic f, input logic [2:0] op, input logic mf,
                             input logic sel, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = v; in_flush = f; in_op = op; in_mf = mf; in_sel = sel;
        rd1 = a; rd2 = b; fa = $urandom; fb = $urandom; ua = 1'b0; ub = 1'b0;
    endtask

    task automatic set_idle();
        set_instr(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk); #1;
        set_instr(1'b1, 1'b0, op, 1'b0, 1'b0, a, b);
        @(posedge clk); #1;
        set_idle();
    endtask

    task automatic wait_idle(output int busy_cycles, output int dz_cycles);
        busy_cycles = 0; dz_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!o_busy) break;
            busy_cycles++;
            if (o_div_by_zero) dz_cycles++;
        end
    endtask

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return W'($urandom_range(0, 20));
            4: return -W'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bc, dc, sc;
        set_idle();
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(o_busy), 64'd0);
        check("reset_hi", 64'(o_hi), 64'd0);
        check("reset_lo", 64'(o_lo), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // MULT -3 * 7
        issue(3'd1, 32'hFFFF_FFFD, 32'd7);
        wait_idle(bc, dc);
`ifdef MULDIV_EARLY_OUT_EN
        check("mult_latency", 64'(bc), 64'd4);
`else
        check("mult_latency", 64'(bc), 64'd33);
`endif
        check("mult_hi", 64'(o_hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(o_lo), 64'hFFFF_FFEB);

        issue(3'd4, 32'd100, 32'd7);
        wait_idle(bc, dc);
        check("divu_lo", 64'(o_lo), 64'd14);
        check("divu_hi", 64'(o_hi), 64'd2);

        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(bc, dc);
        check("div_neg_lo", 64'(o_lo), 64'hFFFF_FFFD);
        check("div_neg_hi", 64'(o_hi), 64'hFFFF_FFFF);

        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(bc, dc);
        check("div_ovf_lo", 64'(o_lo), 64'h8000_0000);
        check("div_ovf_hi", 64'(o_hi), 64'd0);

        issue(3'd3, 32'd5, 32'd0);
        wait_idle(bc, dc);
        check("dz_latency", 64'(bc), 64'd33);
        check("dz_pulses", 64'(dc), 64'd1);
        check("dz_hi", 64'(o_hi), 64'd5);
        check("dz_lo", 64'(o_lo), 64'hFFFF_FFFF);

        // MULTU 6*4, unrelated instruction, then MFLO held until the stall clears
        issue(3'd2, 32'd6, 32'd4);
        set_instr(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'd1, 32'd2);
        @(negedge clk);
        check("add_no_stall", 64'(o_stall), 64'd0);
        @(posedge clk); #1;
        set_idle();
        @(posedge clk); #1;
        set_instr(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, '0, '0);
        sc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!o_stall) break;
            sc++;
        end
`ifdef MULDIV_EARLY_OUT_EN
        check("mflo_stall_cycles", 64'(sc), 64'd2);
`else
        check("mflo_stall_cycles", 64'(sc), 64'd31);
`endif
        check("mflo_value", 64'(o_hilo_read), 64'd24);
        @(posedge clk); #1;
        set_idle();

        issue(3'd2, 32'd3, 32'd5);
        set_instr(1'b1, 1'b0, 3'd5, 1'b0, 1'b1, 32'h1234, '0);
        @(negedge clk);
        check("mthi_stall", 64'(o_stall), 64'd1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!o_stall) break;
        end
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        check("mthi_hi", 64'(o_hi), 64'h1234);
        check("mthi_lo", 64'(o_lo), 64'd15);

        // Forwarded rs, then flushed issues
        @(posedge clk); #1;
        set_instr(1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 32'd99, 32'd4);
        fa = 32'd6; ua = 1'b1;
        @(posedge clk); #1;
        set_idle();
        wait_idle(bc, dc);
        check("fwd_lo", 64'(o_lo), 64'd24);
        check("fwd_hi", 64'(o_hi), 64'd0);
        @(posedge clk); #1;
        set_instr(1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 32'h55, '0);
        @(posedge clk); #1;
        set_instr(1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 32'd9, 32'd9);
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        check("flush_lo", 64'(o_lo), 64'd24);
        check("flush_busy", 64'(o_busy), 64'd0);

        // Reset during RUN cycle 10 of a divide
        issue(3'd3, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_hi", 64'(o_hi), 64'd0);
        check("rst_lo", 64'(o_lo), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(3'd1, 32'hFFFF_FFFD, 32'd7);
        wait_idle(bc, dc);
        check("post_rst_hi", 64'(o_hi), 64'hFFFF_FFFF);
        check("post_rst_lo", 64'(o_lo), 64'hFFFF_FFEB);

        // Randomized instruction stream; a stalled instruction is held in EX
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (!m_last_stall) begin
                set_instr($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0,
                          3'($urandom_range(0, 7)), $urandom_range(0, 6) == 0,
                          1'($urandom_range(0, 1)), rand_val(), rand_val());
                ua = 1'($urandom_range(0, 1));
                ub = 1'($urandom_range(0, 1));
                if (ua) fa = rand_val();
                if (ub) fb = rand_val();
            end
        end
        @(posedge clk); #1;
        set_idle();
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
